// File: rtl/set_assoc_cache.sv
// ---------------------------------------------------------------------------
// set_assoc_cache
//
// N-way set-associative, write-back, write-allocate cache with true-LRU
// replacement.  A single request is handled at a time.  Requests use a
// valid/ready handshake and are answered with a one-cycle response pulse.
// Misses go out over a block-wide backing-memory port that uses a req/ack
// handshake.  A dirty victim is written back before the refill.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (accepted only in IDLE)
//   req_write, req_addr,    request: write flag, block address {tag,index},
//   req_offset, req_wdata   word offset within the block, write data
//   resp_valid              one-cycle response pulse
//   resp_hit, resp_rdata    hit flag and read word (or the written word)
//   mem_req, mem_we         memory transaction pending; 1 = writeback, 0 = refill
//   mem_addr, mem_wdata     block address and victim block (word j at j*DATA_WIDTH)
//   mem_ack, mem_rdata      transaction done; refill block
//   hit_counter, miss_counter, total_requests, writeback_counter
//                           statistics (32-bit, wrapping)
//
// Optional feature: define CACHE_STATS_EN to build the statistics counters.
// Without it the four counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module set_assoc_cache #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_SETS     = 8,
    parameter int WAYS         = 2,
    parameter int BLOCK_SIZE   = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [OFFSET_WIDTH-1:0]            req_offset,
    input  logic [DATA_WIDTH-1:0]              req_wdata,
    output logic                               resp_valid,
    output logic                               resp_hit,
    output logic [DATA_WIDTH-1:0]              resp_rdata,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0]   mem_wdata,
    input  logic                               mem_ack,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0]   mem_rdata,
    output logic [31:0]                        hit_counter,
    output logic [31:0]                        miss_counter,
    output logic [31:0]                        total_requests,
    output logic [31:0]                        writeback_counter
);

    localparam int INDEX_WIDTH = $clog2(NUM_SETS);
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
    localparam int WAY_WIDTH   = $clog2(WAYS);
    localparam int BLOCK_WIDTH = DATA_WIDTH * BLOCK_SIZE;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;

    state_t state, state_next;

    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [OFFSET_WIDTH-1:0] lat_offset;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [WAY_WIDTH-1:0]    victim_q;

    logic [WAYS-1:0]         valid_bits [NUM_SETS];
    logic [WAYS-1:0]         dirty_bits [NUM_SETS];
    logic [WAY_WIDTH-1:0]    age        [NUM_SETS][WAYS];
    logic [TAG_WIDTH-1:0]    tag_mem    [NUM_SETS][WAYS];
    logic [BLOCK_WIDTH-1:0]  data_mem   [NUM_SETS][WAYS];

    logic [INDEX_WIDTH-1:0]  index;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    hit;
    logic [WAY_WIDTH-1:0]    hit_way;
    logic                    victim_found;
    logic [WAY_WIDTH-1:0]    victim_way;
    logic                    touch;
    logic [WAY_WIDTH-1:0]    touch_way;
    logic [BLOCK_WIDTH-1:0]  refill_block;
    logic                    accept;

    assign index  = lat_addr[INDEX_WIDTH-1:0];
    assign tag    = lat_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign accept = (state == IDLE) && req_valid;

    // Tag match across all valid ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_bits[index][w] && tag_mem[index][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
        end
    end

    // Victim: lowest-index invalid way; once the set is full, the way whose
    // age is the maximum (ages are a permutation, so max is WAYS-1).
    always_comb begin
        victim_found = 1'b0;
        victim_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_bits[index][w]) begin
                victim_found = 1'b1;
                victim_way   = WAY_WIDTH'(w);
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[index][w] == WAY_WIDTH'(WAYS - 1)) begin
                    victim_way = WAY_WIDTH'(w);
                end
            end
        end
    end

    // Refill data with the pending write word merged in (write-allocate).
    always_comb begin
        refill_block = mem_rdata;
        if (lat_write) begin
            refill_block[lat_offset*DATA_WIDTH +: DATA_WIDTH] = lat_wdata;
        end
    end

    // A way is "touched" for LRU purposes on a hit and on refill completion.
    assign touch     = ((state == LOOKUP) && hit) || ((state == REFILL) && mem_ack);
    assign touch_way = (state == LOOKUP) ? hit_way : victim_q;

    // Next-state and handshake outputs.  The memory port is driven purely
    // from state so reset drops mem_req immediately.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit)
                    state_next = RESP;
                else if (valid_bits[index][victim_way] && dirty_bits[index][victim_way])
                    state_next = WRITEBACK;
                else
                    state_next = REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[index][victim_q], index};
                mem_wdata = data_mem[index][victim_q];
                if (mem_ack) state_next = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = lat_addr;
                if (mem_ack) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, request latch, response registers, valid/dirty
    // bits and LRU ages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_offset <= '0;
            lat_wdata  <= '0;
            victim_q   <= '0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_bits[s] <= '0;
                dirty_bits[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WAY_WIDTH'(w);
                end
            end
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write  <= req_write;
                lat_addr   <= req_addr;
                lat_offset <= req_offset;
                lat_wdata  <= req_wdata;
            end
            if (state == LOOKUP) begin
                victim_q <= victim_way;
                if (hit) begin
                    resp_hit   <= 1'b1;
                    resp_rdata <= lat_write ? lat_wdata
                                  : data_mem[index][hit_way][lat_offset*DATA_WIDTH +: DATA_WIDTH];
                    if (lat_write) dirty_bits[index][hit_way] <= 1'b1;
                end
            end
            if ((state == WRITEBACK) && mem_ack) begin
                dirty_bits[index][victim_q] <= 1'b0;
            end
            if ((state == REFILL) && mem_ack) begin
                valid_bits[index][victim_q] <= 1'b1;
                dirty_bits[index][victim_q] <= lat_write;
                resp_hit   <= 1'b0;
                resp_rdata <= refill_block[lat_offset*DATA_WIDTH +: DATA_WIDTH];
            end
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age[index][w] < age[index][touch_way]) begin
                        age[index][w] <= age[index][w] + WAY_WIDTH'(1);
                    end
                end
                age[index][touch_way] <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if ((state == LOOKUP) && hit && lat_write) begin
            data_mem[index][hit_way][lat_offset*DATA_WIDTH +: DATA_WIDTH] <= lat_wdata;
        end
        if ((state == REFILL) && mem_ack) begin
            data_mem[index][victim_q] <= refill_block;
            tag_mem[index][victim_q]  <= tag;
        end
    end

`ifdef CACHE_STATS_EN
    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_counter       <= '0;
            miss_counter      <= '0;
            total_requests    <= '0;
            writeback_counter <= '0;
        end else begin
            if (accept) total_requests <= total_requests + 32'd1;
            if (state == LOOKUP) begin
                if (hit) hit_counter  <= hit_counter + 32'd1;
                else     miss_counter <= miss_counter + 32'd1;
            end
            if ((state == WRITEBACK) && mem_ack) begin
                writeback_counter <= writeback_counter + 32'd1;
            end
        end
    end
`else
    assign hit_counter       = '0;
    assign miss_counter      = '0;
    assign total_requests    = '0;
    assign writeback_counter = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// ---------------------------------------------------------------------------
// tb_set_assoc_cache
//
// Self-checking bench for set_assoc_cache with default parameters.  A
// behavioural backing memory answers mem_req after a programmable delay
// (default block content: word j of block A = A*4+j).  A reference model
// keeps the resident lines as a list with access timestamps; the least
// recently used line of a full set is evicted.  Directed scenarios are
// followed by randomized traffic, then a reset in the middle of a refill.
// Statistics expectations follow CACHE_STATS_EN (zero when undefined).
// ---------------------------------------------------------------------------
module tb_set_assoc_cache;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int NS   = 8;
    localparam int WAYS = 2;
    localparam int BS   = 4;
    localparam int OW   = 2;
    localparam int IW   = 3;
    localparam int BW   = DW * BS;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [OW-1:0] req_offset;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_hit;
    logic [DW-1:0] resp_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_ack;
    logic [BW-1:0] mem_rdata;
    logic [31:0]   hit_counter;
    logic [31:0]   miss_counter;
    logic [31:0]   total_requests;
    logic [31:0]   writeback_counter;

    set_assoc_cache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SETS(NS), .WAYS(WAYS),
        .BLOCK_SIZE(BS), .OFFSET_WIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_counter(hit_counter), .miss_counter(miss_counter),
        .total_requests(total_requests), .writeback_counter(writeback_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit stuck       = 0;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [BW-1:0] defaultBlock(input logic [AW-1:0] a);
        logic [BW-1:0] b;
        for (int j = 0; j < BS; j++) b[j*DW +: DW] = DW'(32'(a) * 4 + j);
        return b;
    endfunction

    // Backing memory seen by the DUT, plus the transactions it observed.
    logic [BW-1:0] dut_mem [logic [AW-1:0]];
    logic [AW-1:0] obs_wb_addr [$];
    logic [BW-1:0] obs_wb_data [$];
    logic [AW-1:0] obs_refill  [$];
    int ack_delay = 3;
    int mem_cnt   = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (reset || !mem_req) begin
            mem_cnt = 0;
        end else if (mem_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            mem_cnt = 0;
            if (mem_we) begin
                obs_wb_addr.push_back(mem_addr);
                obs_wb_data.push_back(mem_wdata);
                dut_mem[mem_addr] = mem_wdata;
            end else begin
                obs_refill.push_back(mem_addr);
                mem_rdata = dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : defaultBlock(mem_addr);
            end
        end else begin
            mem_cnt++;
        end
    end

    // Accept / response bookkeeping.
    int accepts   = 0;
    int responses = 0;
    always @(posedge clk) begin
        if (reset) begin
            accepts   = 0;
            responses = 0;
        end else begin
            if (req_valid && req_ready) accepts++;
            if (resp_valid) responses++;
        end
    end

    // Reference model: resident lines with last-access timestamps.
    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        bit            dirty;
        int            stamp;
    } line_t;

    line_t         lines [$];
    logic [BW-1:0] ref_mem [logic [AW-1:0]];
    int stamp_now = 0;
    int m_hits = 0, m_misses = 0, m_total = 0, m_wbs = 0;

    function automatic logic [63:0] expStat(input int v);
`ifdef CACHE_STATS_EN
        return 64'(v);
`else
        return 64'(v) & 64'd0;
`endif
    endfunction

    task automatic modelAccess(input bit wr, input logic [AW-1:0] addr, input logic [OW-1:0] off,
                               input logic [DW-1:0] wd, output bit hit, output logic [DW-1:0] rdata,
                               output bit wb, output logic [AW-1:0] wb_addr,
                               output logic [BW-1:0] wb_data);
        int    found  = -1;
        int    in_set = 0;
        int    oldest = -1;
        line_t ln;
        stamp_now++;
        m_total++;
        wb      = 0;
        wb_addr = '0;
        wb_data = '0;
        foreach (lines[i]) if (lines[i].addr == addr) found = i;
        if (found >= 0) begin
            hit = 1;
            m_hits++;
            ln = lines[found];
            if (wr) begin
                ln.data[off*DW +: DW] = wd;
                ln.dirty = 1;
            end
            ln.stamp = stamp_now;
            lines[found] = ln;
        end else begin
            hit = 0;
            m_misses++;
            foreach (lines[i]) begin
                if (lines[i].addr[IW-1:0] == addr[IW-1:0]) begin
                    in_set++;
                    if (oldest < 0 || lines[i].stamp < lines[oldest].stamp) oldest = i;
                end
            end
            if (in_set == WAYS) begin
                if (lines[oldest].dirty) begin
                    wb      = 1;
                    m_wbs++;
                    wb_addr = lines[oldest].addr;
                    wb_data = lines[oldest].data;
                    ref_mem[wb_addr] = wb_data;
                end
                lines.delete(oldest);
            end
            ln.addr  = addr;
            ln.data  = ref_mem.exists(addr) ? ref_mem[addr] : defaultBlock(addr);
            if (wr) ln.data[off*DW +: DW] = wd;
            ln.dirty = wr;
            ln.stamp = stamp_now;
            lines.push_back(ln);
        end
        rdata = ln.data[off*DW +: DW];
    endtask

    bit            last_hit;
    logic [DW-1:0] last_rdata;
    int            last_wb_cnt;
    logic [AW-1:0] last_wb_addr;
    logic [BW-1:0] last_wb_data;
    logic [AW-1:0] last_refill;

    // Issues one request, waits for its response and checks everything
    // against the model.  With hold set, req_valid stays high afterwards.
    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [OW-1:0] off,
                                 input logic [DW-1:0] wd, input bit hold);
        bit            e_hit, e_wb;
        logic [DW-1:0] e_rd;
        logic [AW-1:0] e_wba;
        logic [BW-1:0] e_wbd;
        int            n, guard;
        bit            mem_seen, ready_bad, unstable, prev_req, prev_we;
        logic [AW-1:0] prev_addr;
        logic [BW-1:0] prev_wdata;

        modelAccess(wr, addr, off, wd, e_hit, e_rd, e_wb, e_wba, e_wbd);
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 64'(req_ready), 64'd1);
            stuck = 1;
            return;
        end
        obs_wb_addr.delete();
        obs_wb_data.delete();
        obs_refill.delete();
        req_write  = wr;
        req_addr   = addr;
        req_offset = off;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        n = 1; mem_seen = 0; ready_bad = 0; unstable = 0; prev_req = 0; prev_we = 0;
        prev_addr = '0; prev_wdata = '0;
        while (!resp_valid && n < 400) begin
            if (req_ready) ready_bad = 1;
            if (mem_req) begin
                mem_seen = 1;
                if (prev_req && prev_we == mem_we && (prev_addr != mem_addr || prev_wdata != mem_wdata))
                    unstable = 1;
            end
            prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr; prev_wdata = mem_wdata;
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
            stuck = 1;
            return;
        end
        last_hit     = resp_hit;
        last_rdata   = resp_rdata;
        last_wb_cnt  = obs_wb_addr.size();
        last_wb_addr = (obs_wb_addr.size() > 0) ? obs_wb_addr[0] : '0;
        last_wb_data = (obs_wb_data.size() > 0) ? obs_wb_data[0] : '0;
        last_refill  = (obs_refill.size() > 0) ? obs_refill[0] : '0;

        checkOutput("resp_hit", 64'(resp_hit), 64'(e_hit));
        checkOutput("resp_rdata", 64'(resp_rdata), 64'(e_rd));
        if (e_hit) begin
            checkOutput("hit_latency", 64'(n), 64'd2);
            checkOutput("hit_mem_req", 64'(mem_seen), 64'd0);
        end
        checkOutput("wb_count", 64'(obs_wb_addr.size()), 64'(e_wb));
        if (e_wb && obs_wb_addr.size() > 0) begin
            checkOutput("wb_addr", 64'(obs_wb_addr[0]), 64'(e_wba));
            checkOutput("wb_data", obs_wb_data[0], e_wbd);
        end
        checkOutput("refill_count", 64'(obs_refill.size()), e_hit ? 64'd0 : 64'd1);
        if (!e_hit && obs_refill.size() > 0) checkOutput("refill_addr", 64'(obs_refill[0]), 64'(addr));
        checkOutput("ready_while_busy", 64'(ready_bad), 64'd0);
        checkOutput("mem_stable", 64'(unstable), 64'd0);
        checkOutput("hit_counter", 64'(hit_counter), expStat(m_hits));
        checkOutput("miss_counter", 64'(miss_counter), expStat(m_misses));
        checkOutput("total_requests", 64'(total_requests), expStat(m_total));
        checkOutput("writeback_counter", 64'(writeback_counter), expStat(m_wbs));
        @(negedge clk);
        checkOutput("resp_pulse", 64'(resp_valid), 64'd0);
        checkOutput("accept_per_resp", 64'(accepts), 64'(responses));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit            rst_resp;
        bit            d_hit, d_wb;
        logic [DW-1:0] d_rd;
        logic [AW-1:0] d_wba;
        logic [BW-1:0] d_wbd;
        int            guard;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_offset = '0;
        req_wdata  = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_total", 64'(total_requests), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, then hit in the same block.
        applyStimulus(0, 16'h0010, 2'd1, 16'h0, 0);
        checkOutput("t1_hit", 64'(last_hit), 64'd0);
        checkOutput("t1_rdata", 64'(last_rdata), 64'h0041);
        checkOutput("t1_refill", 64'(last_refill), 64'h0010);
        checkOutput("t1_no_wb", 64'(last_wb_cnt), 64'd0);
        applyStimulus(0, 16'h0010, 2'd2, 16'h0, 0);
        checkOutput("t2_hit", 64'(last_hit), 64'd1);
        checkOutput("t2_rdata", 64'(last_rdata), 64'h0042);

        // Write-allocate into the second way of set 0, then read it back.
        applyStimulus(1, 16'h0030, 2'd3, 16'hCCCC, 0);
        checkOutput("t3_whit", 64'(last_hit), 64'd0);
        applyStimulus(0, 16'h0030, 2'd3, 16'h0, 0);
        checkOutput("t3_rhit", 64'(last_hit), 64'd1);
        checkOutput("t3_rdata", 64'(last_rdata), 64'hCCCC);

        // Clean eviction, then dirty eviction with writeback.
        applyStimulus(0, 16'h0050, 2'd0, 16'h0, 0);
        checkOutput("t4_clean_no_wb", 64'(last_wb_cnt), 64'd0);
        applyStimulus(0, 16'h0070, 2'd0, 16'h0, 0);
        checkOutput("t4_wb_addr", 64'(last_wb_addr), 64'h0030);
        checkOutput("t4_wb_word3", 64'(last_wb_data[63:48]), 64'hCCCC);
        checkOutput("t4_refill", 64'(last_refill), 64'h0070);

        // Slow memory with req_valid held high across requests.
        ack_delay = 10;
        applyStimulus(0, 16'h0090, 2'd0, 16'h0, 1);
        applyStimulus(1, 16'h00B0, 2'd1, 16'h1234, 1);
        applyStimulus(0, 16'h0090, 2'd0, 16'h0, 0);
        req_valid = 1'b0;

        // Randomized traffic concentrated on two sets.
        for (int k = 0; k < 150; k++) begin
            int            tg, ix;
            logic [AW-1:0] a;
            if (stuck) break;
            ack_delay = $urandom_range(0, 4);
            tg = $urandom_range(0, 5);
            ix = $urandom_range(0, 1);
            a  = AW'((tg << IW) | ix);
            applyStimulus(1'($urandom_range(0, 1)), a, OW'($urandom_range(0, 3)),
                          DW'($urandom), ($urandom_range(0, 3) == 0));
            req_valid = 1'b0;
        end

        // Reset in the middle of a refill.
        if (!stuck) begin
            ack_delay = 50;
            while (!req_ready) @(negedge clk);
            modelAccess(0, 16'h7F00, 2'd0, 16'h0, d_hit, d_rd, d_wb, d_wba, d_wbd);
            req_write = 1'b0; req_addr = 16'h7F00; req_offset = '0; req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            guard = 0;
            while (!(mem_req && !mem_we) && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("t6_in_refill", 64'(mem_req && !mem_we), 64'd1);
            reset = 1'b1;
            #1;
            checkOutput("t6_mem_req_drop", 64'(mem_req), 64'd0);
            checkOutput("t6_req_ready", 64'(req_ready), 64'd1);
            checkOutput("t6_total", 64'(total_requests), 64'd0);
            checkOutput("t6_miss", 64'(miss_counter), 64'd0);
            rst_resp = 0;
            repeat (3) begin
                @(negedge clk);
                if (resp_valid) rst_resp = 1;
            end
            reset = 1'b0;
            lines.delete();
            m_hits = 0; m_misses = 0; m_total = 0; m_wbs = 0;
            ack_delay = 3;
            @(negedge clk);
            if (resp_valid) rst_resp = 1;
            checkOutput("t6_no_resp", 64'(rst_resp), 64'd0);
            applyStimulus(0, 16'h0010, 2'd0, 16'h0, 0);
            checkOutput("t6_after_miss", 64'(last_hit), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
